mcyc_core_param: RTL



---
 rtl/mcyc_core_param.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/mcyc_core_param.sv
// mcyc_core_param: multi-cycle 8-bit-instruction core with a loadable
// instruction memory, a 4-entry register file and a data memory. Every
// instruction passes through FETCH/DECODE/EXEC and optionally MEM and/or WB.
//
// Ports:
//   clk         in   clock, all state updates on the rising edge
//   rst         in   synchronous active-high reset
//   run         in   start pulse, accepted in IDLE or HALT (restarts at pc 0)
//   imem_we     in   instruction-memory write strobe (IDLE/HALT only)
//   imem_waddr  in   instruction-memory write address
//   imem_wdata  in   instruction word to write
//   dbg_raddr   in   debug register index
//   dbg_rdata   out  combinational read of regfile[dbg_raddr]
//   pc          out  current program counter
//   state       out  FSM state (IDLE=0 .. HALT=6)
//   halted      out  high while in HALT
//   busy        out  high in FETCH..WB
module mcyc_core_param #(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int DMEM_DEPTH = 16,
  localparam int PW        = $clog2(IMEM_DEPTH),
  localparam int AW        = $clog2(DMEM_DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  input  logic              imem_we,
  input  logic [PW-1:0]     imem_waddr,
  input  logic [7:0]        imem_wdata,
  input  logic [1:0]        dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic [PW-1:0]     pc,
  output logic [2:0]        state,
  output logic              halted,
  output logic              busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_HALT = 3'b010;
  localparam logic [2:0] OP_ADDI = 3'b011;
  localparam logic [2:0] OP_BEQZ = 3'b100;
  localparam logic [2:0] OP_SW   = 3'b101;
  localparam logic [2:0] OP_LW   = 3'b110;
  localparam logic [2:0] OP_SLL  = 3'b111;

  function automatic logic [DATA_W-1:0] sext_imm(input logic [2:0] imm);
    return {{(DATA_W-3){imm[2]}}, imm};
  endfunction

  // Branch target relative to the branch's own address, wrapping in PW bits.
  function automatic logic [PW-1:0] branch_target(input logic [PW-1:0] cur,
                                                  input logic [2:0] imm);
    logic [PW-1:0] off;
    off = PW'({{29{imm[2]}}, imm});
    return cur + off;
  endfunction

  state_e            state_q, state_d;
  logic [PW-1:0]     pc_q, pc_d;
  logic [7:0]        ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic              rf_we, dmem_we;

  logic [7:0]        imem_q [IMEM_DEPTH];
  logic [DATA_W-1:0] rf_q   [4];
  logic [DATA_W-1:0] dmem_q [DMEM_DEPTH];

  logic [2:0] op;
  logic [1:0] ra, rb;
  logic [2:0] imm;
  assign op  = ir_q[7:5];
  assign ra  = ir_q[4:3];
  assign rb  = ir_q[2:1];
  assign imm = ir_q[2:0];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    rf_we   = 1'b0;
    dmem_we = 1'b0;
    case (state_q)
      S_IDLE, S_HALT: begin
        if (run) begin
          pc_d    = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = imem_q[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d = rf_q[ra];
        // B carries the immediate for ADDI/SLL, otherwise the rb register
        // (which is also the memory address for LW/SW).
        if (op == OP_ADDI)     b_d = sext_imm(imm);
        else if (op == OP_SLL) b_d = {{(DATA_W-3){1'b0}}, imm};
        else                   b_d = rf_q[rb];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WB;
        case (op)
          OP_ADD, OP_ADDI: res_d = a_q + b_q;
          OP_SUB:          res_d = a_q - b_q;
          // Logical shift by up to 7 naturally yields 0 once it reaches DATA_W.
          OP_SLL:          res_d = a_q << b_q[2:0];
          OP_LW, OP_SW: begin
            res_d   = b_q;
            state_d = S_MEM;
          end
          OP_BEQZ: begin
            pc_d    = (a_q == '0) ? branch_target(pc_q, imm) : pc_q + PW'(1);
            state_d = S_FETCH;
          end
          default: state_d = S_HALT;
        endcase
      end
      S_MEM: begin
        if (op == OP_SW) begin
          dmem_we = 1'b1;
          pc_d    = pc_q + PW'(1);
          state_d = S_FETCH;
        end else begin
          res_d   = dmem_q[res_q[AW-1:0]];
          state_d = S_WB;
        end
      end
      S_WB: begin
        rf_we   = 1'b1;
        pc_d    = pc_q + PW'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      if (rf_we)   rf_q[ra] <= res_q;
      if (dmem_we) dmem_q[res_q[AW-1:0]] <= a_q;
    end
  end

  // Instruction memory survives reset; loads only while the core is parked.
  always_ff @(posedge clk) begin
    if (!rst && imem_we && (state_q == S_IDLE || state_q == S_HALT))
      imem_q[imem_waddr] <= imem_wdata;
  end

  assign dbg_rdata = rf_q[dbg_raddr];
  assign pc        = pc_q;
  assign state     = state_q;
  assign halted    = (state_q == S_HALT);
  assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);

endmodule
